// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU_4 self-test controller.
// Pass encodings, FSM states and the fail-vector field layout.
package alu_pkg;

    typedef enum logic [1:0] {
        PASS_LOGIC = 2'd0,
        PASS_ADD   = 2'd1,
        PASS_ADD_C = 2'd2
    } pass_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NUM_VEC = 12288;

    // Five disjoint fields: m, cin, s[3:0], b[3:0], a[3:0].
    localparam int FV_W   = 14;
    localparam int FV_A   = 0;
    localparam int FV_B   = 4;
    localparam int FV_S   = 8;
    localparam int FV_CIN = 12;
    localparam int FV_M   = 13;

    function automatic logic [FV_W-1:0] pack_vec(
        input logic       m,
        input logic       cin,
        input logic [3:0] s,
        input logic [3:0] b,
        input logic [3:0] a
    );
        logic [FV_W-1:0] pv;
        pv             = '0;
        pv[FV_M]       = m;
        pv[FV_CIN]     = cin;
        pv[FV_S +: 4]  = s;
        pv[FV_B +: 4]  = b;
        pv[FV_A +: 4]  = a;
        return pv;
    endfunction

endpackage

// File: rtl/alu_4_ref_model.sv
// Combinational golden model of the 74181-style ALU_4.
// Logic mode yields f only; arithmetic mode yields {cout, f} = P + Q + cin.
module alu_4_ref_model
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] exp_f,
    output logic       exp_cout,
    output logic       cout_valid
);

    logic [3:0] lf;
    logic [3:0] p;
    logic [3:0] q;
    logic [4:0] sum;

    always_comb begin
        lf = '0;
        unique case (s)
            4'd0:  lf = ~a;
            4'd1:  lf = ~(a | b);
            4'd2:  lf = ~a & b;
            4'd3:  lf = 4'b0000;
            4'd4:  lf = ~(a & b);
            4'd5:  lf = ~b;
            4'd6:  lf = a ^ b;
            4'd7:  lf = a & ~b;
            4'd8:  lf = ~a | b;
            4'd9:  lf = ~(a ^ b);
            4'd10: lf = b;
            4'd11: lf = a & b;
            4'd12: lf = 4'b1111;
            4'd13: lf = a | ~b;
            4'd14: lf = a | b;
            4'd15: lf = a;
            default: lf = '0;
        endcase
    end

    always_comb begin
        p = '0;
        q = '0;
        unique case (s)
            4'd0:  begin p = a;          q = 4'b0000;   end
            4'd1:  begin p = a | b;      q = 4'b0000;   end
            4'd2:  begin p = a | ~b;     q = 4'b0000;   end
            4'd3:  begin p = 4'b0000;    q = 4'b1111;   end
            4'd4:  begin p = a;          q = a & ~b;    end
            4'd5:  begin p = a | b;      q = a & ~b;    end
            4'd6:  begin p = a;          q = ~b;        end
            4'd7:  begin p = a & ~b;     q = 4'b1111;   end
            4'd8:  begin p = a;          q = a & b;     end
            4'd9:  begin p = a;          q = b;         end
            4'd10: begin p = a | ~b;     q = a & b;     end
            4'd11: begin p = a & b;      q = 4'b1111;   end
            4'd12: begin p = a;          q = a;         end
            4'd13: begin p = a | b;      q = a;         end
            4'd14: begin p = a | ~b;     q = a;         end
            4'd15: begin p = a;          q = 4'b1111;   end
            default: begin p = '0;       q = '0;        end
        endcase
        sum = {1'b0, p} + {1'b0, q} + {4'b0000, cin};
    end

    assign exp_f      = m ? lf : sum[3:0];
    assign exp_cout   = m ? 1'b0 : sum[4];
    assign cout_valid = ~m;

endmodule

// File: rtl/alu_4_bist.sv
// Built-in self-test sweep controller for ALU_4.
// Drives every vector, compares against the golden model, records errors.
module alu_4_bist
    import alu_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             cin,
    output logic             m,
    input  logic [3:0]       f,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [FV_W-1:0]  fail_vec,
    output logic [4:0]       fail_f
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q;
    state_e           state_d;
    pass_e            pass_q;
    pass_e            pass_nx;
    logic [3:0]       sel_q;
    logic [7:0]       idx_q;
    logic             m_q;
    logic             cin_q;
    logic [SW-1:0]    settle_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_nx;
    logic             pass_r;
    logic             fv_q;
    logic [FV_W-1:0]  fvec_q;
    logic [4:0]       ff_q;

    logic [3:0] exp_f;
    logic       exp_cout;
    logic       cout_valid;
    logic       go;
    logic       cmp;
    logic       last;
    logic       mismatch;

    alu_4_ref_model u_ref (
        .a          (idx_q[3:0]),
        .b          (idx_q[7:4]),
        .s          (sel_q),
        .m          (m_q),
        .cin        (cin_q),
        .exp_f      (exp_f),
        .exp_cout   (exp_cout),
        .cout_valid (cout_valid)
    );

    assign go   = start && (state_q != ST_RUN);
    assign cmp  = (state_q == ST_RUN) && !abort
               && (settle_q == SW'(SETTLE - 1));
    assign last = (pass_q == PASS_ADD_C) && (sel_q == 4'hF)
               && (idx_q == 8'hFF);

    assign mismatch = (f != exp_f)
                   || (cout_valid && (cout != exp_cout));

    always_comb begin
        err_nx = err_q;
        if (cmp && mismatch && !(&err_q))
            err_nx = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    always_comb begin
        pass_nx = PASS_LOGIC;
        unique case (pass_q)
            PASS_LOGIC: pass_nx = PASS_ADD;
            PASS_ADD:   pass_nx = PASS_ADD_C;
            default:    pass_nx = PASS_ADD_C;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (cmp && last)
                    state_d = ST_DONE;
            end
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q   <= PASS_LOGIC;
            sel_q    <= '0;
            idx_q    <= '0;
            m_q      <= 1'b0;
            cin_q    <= 1'b0;
            settle_q <= '0;
            err_q    <= '0;
            pass_r   <= 1'b0;
            fv_q     <= 1'b0;
            fvec_q   <= '0;
            ff_q     <= '0;
        end else if (go) begin
            pass_q   <= PASS_LOGIC;
            sel_q    <= '0;
            idx_q    <= '0;
            m_q      <= 1'b1;
            cin_q    <= 1'b0;
            settle_q <= '0;
            err_q    <= '0;
            pass_r   <= 1'b0;
            fv_q     <= 1'b0;
            fvec_q   <= '0;
            ff_q     <= '0;
        end else if (cmp) begin
            err_q    <= err_nx;
            settle_q <= '0;
            if (mismatch && !fv_q) begin
                fv_q   <= 1'b1;
                fvec_q <= pack_vec(m_q, cin_q, sel_q,
                                   idx_q[7:4], idx_q[3:0]);
                ff_q   <= {cout, f};
            end
            if (last) begin
                pass_r <= (err_nx == '0);
            end else begin
                idx_q <= idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    sel_q <= sel_q + 4'd1;
                    if (sel_q == 4'hF) begin
                        pass_q <= pass_nx;
                        m_q    <= (pass_nx == PASS_LOGIC);
                        cin_q  <= (pass_nx == PASS_ADD_C);
                    end
                end
            end
        end else if (busy && !abort) begin
            settle_q <= settle_q + SW'(1);
        end
    end

    assign a          = idx_q[3:0];
    assign b          = idx_q[7:4];
    assign s0         = sel_q[0];
    assign s1         = sel_q[1];
    assign s2         = sel_q[2];
    assign s3         = sel_q[3];
    assign m          = m_q;
    assign cin        = cin_q;
    assign pass       = pass_r;
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;
    assign fail_f     = ff_q;

endmodule
